pc_stack: RTL and testbench

Parametrised program-counter unit for the single-cycle core: holds the fetch address and updates it once per clock by increment, relative branch, absolute jump, call or return. It adds a hardware return-address stack, a stall/hold input and sticky error flags. It sits between the control decoder and instruction memory, driving the instruction-ROM address directly.

---
 rtl/pc_pkg.sv | 39 +++
 rtl/ret_stack.sv | 60 ++++++
 rtl/pc_stack.sv | 99 +++++++++
 tb/tb_pc_stack.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_pkg: PC operation encoding, priority select and stack-depth sizing |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pc_pkg;

    typedef enum logic [2:0] {
        PC_INC  = 3'd0,
        PC_REL  = 3'd1,
        PC_ABS  = 3'd2,
        PC_CALL = 3'd3,
        PC_RET  = 3'd4,
        PC_HOLD = 3'd5
    } pc_op_e;

    // Fixed priority: stall > ret > call > abs > rel > increment.
    function automatic pc_op_e pc_sel(
        input logic stall,
        input logic ret_en,
        input logic call_en,
        input logic absjump_en,
        input logic reljump_en
    );
        if (stall)           return PC_HOLD;
        else if (ret_en)     return PC_RET;
        else if (call_en)    return PC_CALL;
        else if (absjump_en) return PC_ABS;
        else if (reljump_en) return PC_REL;
        else                 return PC_INC;
    endfunction

    // Width needed to count 0..depth inclusive.
    function automatic int depth_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ret_stack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ret_stack: LIFO return-address array with depth pointer and flags    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ret_stack
    import pc_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic                        pop,
    input  logic [WIDTH-1:0]            push_data,
    output logic [WIDTH-1:0]            top_data,
    output logic [depth_w(DEPTH)-1:0]   depth,
    output logic                        full,
    output logic                        empty
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_dw = depth_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_dw-1:0]  r_depth;
    logic             w_push;
    logic             w_pop;
    logic [c_aw-1:0]  w_top_ptr;

    assign full   = (r_depth == c_dw'(DEPTH));
    assign empty  = (r_depth == '0);
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    // Low bits of a full count are zero, so the decrement wraps to DEPTH-1.
    assign w_top_ptr = r_depth[c_aw-1:0] - c_aw'(1);
    assign top_data  = r_mem[w_top_ptr];
    assign depth     = r_depth;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_depth <= '0;
        end else if (w_push) begin
            r_depth <= r_depth + c_dw'(1);
        end else if (w_pop) begin
            r_depth <= r_depth - c_dw'(1);
        end
    end

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_depth[c_aw-1:0]] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_stack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_stack: program counter with return stack, stall and sticky errors |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pc_stack
    import pc_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int OFFW  = 8,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stall,
    input  logic                        reljump_en,
    input  logic                        absjump_en,
    input  logic                        call_en,
    input  logic                        ret_en,
    input  logic                        err_clr,
    input  logic [OFFW-1:0]             offset,
    input  logic [WIDTH-1:0]            target,
    output logic [WIDTH-1:0]            prog_ctr,
    output logic [depth_w(DEPTH)-1:0]   ret_depth,
    output logic                        stack_full,
    output logic                        stack_empty,
    output logic                        overflow,
    output logic                        underflow
);

    pc_op_e           w_op;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_inc;
    logic [WIDTH-1:0] w_off_ext;
    logic [WIDTH-1:0] w_top;
    logic [WIDTH-1:0] w_pc_next;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             r_overflow;
    logic             r_underflow;

    assign w_op      = pc_sel(stall, ret_en, call_en, absjump_en, reljump_en);
    assign w_pc_inc  = r_pc + WIDTH'(1);
    assign w_off_ext = WIDTH'($signed(offset));
    assign w_push    = (w_op == PC_CALL);
    assign w_pop     = (w_op == PC_RET);

    ret_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_inc),
        .top_data  (w_top),
        .depth     (ret_depth),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_comb begin
        w_pc_next = w_pc_inc;
        case (w_op)
            PC_HOLD: w_pc_next = r_pc;
            PC_RET:  w_pc_next = w_empty ? w_pc_inc : w_top;
            PC_CALL: w_pc_next = target;
            PC_ABS:  w_pc_next = target;
            PC_REL:  w_pc_next = r_pc + w_off_ext;
            default: w_pc_next = w_pc_inc;
        endcase
    end

    // A fresh error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc        <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_pc <= w_pc_next;
            if (w_op != PC_HOLD) begin
                r_overflow  <= (w_push & w_full)  | (r_overflow  & ~err_clr);
                r_underflow <= (w_pop  & w_empty) | (r_underflow & ~err_clr);
            end
        end
    end

    assign prog_ctr    = r_pc;
    assign stack_full  = w_full;
    assign stack_empty = w_empty;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_pc_stack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pc_stack: directed self-checking bench for pc_stack               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pc_stack;

    localparam int WIDTH = 12;
    localparam int OFFW  = 8;
    localparam int DEPTH = 4;

    logic              clk;
    logic              reset;
    logic              stall;
    logic              reljump_en;
    logic              absjump_en;
    logic              call_en;
    logic              ret_en;
    logic              err_clr;
    logic [OFFW-1:0]   offset;
    logic [WIDTH-1:0]  target;
    logic [WIDTH-1:0]  prog_ctr;
    logic [2:0]        ret_depth;
    logic              stack_full;
    logic              stack_empty;
    logic              overflow;
    logic              underflow;

    int n_cmp;
    int n_err;

    pc_stack #(
        .WIDTH (WIDTH),
        .OFFW  (OFFW),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .reljump_en  (reljump_en),
        .absjump_en  (absjump_en),
        .call_en     (call_en),
        .ret_en      (ret_en),
        .err_clr     (err_clr),
        .offset      (offset),
        .target      (target),
        .prog_ctr    (prog_ctr),
        .ret_depth   (ret_depth),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; reljump_en = 0; absjump_en = 0; call_en = 0; ret_en = 0; err_clr = 0;
    endtask

    task automatic do_abs(input logic [WIDTH-1:0] t);
        absjump_en = 1; target = t;
        cyc();
        idle();
    endtask

    task automatic do_call(input logic [WIDTH-1:0] t);
        call_en = 1; target = t;
        cyc();
        idle();
    endtask

    task automatic do_ret();
        ret_en = 1;
        cyc();
        idle();
    endtask

    logic [WIDTH-1:0] exp_ret [4];

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1;
        offset = '0;
        target = '0;
        idle();
        #12;
        check("rst_pc",    32'(prog_ctr),    32'h0);
        check("rst_depth", 32'(ret_depth),   32'h0);
        check("rst_empty", 32'(stack_empty), 32'h1);
        check("rst_full",  32'(stack_full),  32'h0);
        check("rst_ovf",   32'(overflow),    32'h0);
        check("rst_unf",   32'(underflow),   32'h0);
        @(negedge clk);
        reset = 0;

        // Increment sequence 0..4
        check("inc0", 32'(prog_ctr), 32'h0);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            check($sformatf("inc%0d", i), 32'(prog_ctr), 32'(i));
        end
        check("inc_depth", 32'(ret_depth), 32'h0);

        // Relative branches
        do_abs(12'h010);
        check("abs_010", 32'(prog_ctr), 32'h010);
        reljump_en = 1; offset = 8'hFC;
        cyc(); idle();
        check("rel_neg4", 32'(prog_ctr), 32'h00C);
        do_abs(12'hFFE);
        reljump_en = 1; offset = 8'h03;
        cyc(); idle();
        check("rel_wrap", 32'(prog_ctr), 32'h001);
        reljump_en = 1; offset = 8'h00;
        cyc(); idle();
        check("rel_zero", 32'(prog_ctr), 32'h001);
        do_abs(12'hFFF);
        cyc();
        check("inc_wrap", 32'(prog_ctr), 32'h000);

        // Nested call / return
        do_abs(12'h020);
        do_call(12'h100);
        check("call1_pc", 32'(prog_ctr), 32'h100);
        check("call1_d",  32'(ret_depth), 32'h1);
        cyc();
        check("pc_101", 32'(prog_ctr), 32'h101);
        do_call(12'h200);
        check("call2_pc", 32'(prog_ctr), 32'h200);
        check("call2_d",  32'(ret_depth), 32'h2);
        do_ret();
        check("ret1_pc", 32'(prog_ctr), 32'h102);
        check("ret1_d",  32'(ret_depth), 32'h1);
        do_ret();
        check("ret2_pc", 32'(prog_ctr), 32'h021);
        check("ret2_d",  32'(ret_depth), 32'h0);

        // Fill to DEPTH then one extra call
        exp_ret[0] = 12'h022; exp_ret[1] = 12'h301; exp_ret[2] = 12'h311; exp_ret[3] = 12'h321;
        for (int i = 0; i < DEPTH; i++) begin
            do_call(12'h300 + 12'(i * 16));
            check($sformatf("fill%0d_d", i), 32'(ret_depth), 32'(i + 1));
        end
        check("full_set", 32'(stack_full), 32'h1);
        check("ovf_pre",  32'(overflow),   32'h0);
        do_call(12'h340);
        check("ovf_pc",  32'(prog_ctr),  32'h340);
        check("ovf_set", 32'(overflow),  32'h1);
        check("ovf_d",   32'(ret_depth), 32'h4);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            do_ret();
            check($sformatf("unwind%0d", i), 32'(prog_ctr), 32'(exp_ret[i]));
        end
        check("unwind_empty", 32'(stack_empty), 32'h1);
        check("ovf_sticky",   32'(overflow),    32'h1);
        err_clr = 1;
        cyc(); idle();
        check("ovf_clr", 32'(overflow), 32'h0);
        check("clr_pc",  32'(prog_ctr), 32'h023);

        // Underflow and stall
        do_abs(12'h050);
        stall = 1; ret_en = 1;
        cyc(); idle();
        check("stall_pc",  32'(prog_ctr),  32'h050);
        check("stall_unf", 32'(underflow), 32'h0);
        do_ret();
        check("unf_pc",  32'(prog_ctr),  32'h051);
        check("unf_set", 32'(underflow), 32'h1);
        check("unf_ovf", 32'(overflow),  32'h0);
        stall = 1; err_clr = 1;
        cyc(); idle();
        check("stall_clr_unf", 32'(underflow), 32'h1);
        check("stall_clr_pc",  32'(prog_ctr),  32'h051);
        ret_en = 1; err_clr = 1;
        cyc(); idle();
        check("set_wins_unf", 32'(underflow), 32'h1);
        check("set_wins_pc",  32'(prog_ctr),  32'h052);
        err_clr = 1;
        cyc(); idle();
        check("unf_clr", 32'(underflow), 32'h0);
        check("unf_clr_pc", 32'(prog_ctr), 32'h053);

        // Priority resolution
        do_call(12'h400);
        check("pri_call_d", 32'(ret_depth), 32'h1);
        ret_en = 1; call_en = 1; absjump_en = 1; target = 12'h500;
        cyc(); idle();
        check("pri_ret_pc", 32'(prog_ctr),  32'h054);
        check("pri_ret_d",  32'(ret_depth), 32'h0);
        absjump_en = 1; reljump_en = 1; target = 12'h600; offset = 8'h05;
        cyc(); idle();
        check("pri_abs_pc", 32'(prog_ctr), 32'h600);
        call_en = 1; absjump_en = 1; target = 12'h610;
        cyc(); idle();
        check("pri_call_pc", 32'(prog_ctr),  32'h610);
        check("pri_call_d2", 32'(ret_depth), 32'h1);

        // Asynchronous reset between edges
        @(posedge clk);
        #2;
        reset = 1;
        #1;
        check("arst_pc", 32'(prog_ctr),  32'h0);
        check("arst_d",  32'(ret_depth), 32'h0);
        reset = 0;
        cyc();
        check("arst_after", 32'(prog_ctr), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
